// File: rtl/rs_dsp_mult_arb_pkg.sv
// Shared widths, constants and pipeline entry type for the DSP38 multiplier arbiter.
package rs_dsp_mult_arb_pkg;

    localparam int A_W       = 20;
    localparam int B_W       = 18;
    localparam int Z_W       = 38;
    localparam int RSP_DEPTH = 4;
    localparam int ID_MAX_W  = 3;   // wide enough for up to 8 requesters

    localparam logic [2:0] FEEDBACK_MULT = 3'b000;

    typedef struct packed {
        logic                valid;
        logic [ID_MAX_W-1:0] id;
        logic [A_W-1:0]      a;
        logic [B_W-1:0]      b;
        logic                unsigned_a;
        logic                unsigned_b;
    } pipe_entry_t;

    // Extending both operands to the result width makes the truncated product
    // exact for every signedness combination.
    function automatic logic [Z_W-1:0] dsp_mult(
        input logic [A_W-1:0] a,
        input logic [B_W-1:0] b,
        input logic           ua,
        input logic           ub
    );
        logic [Z_W-1:0] w_a;
        logic [Z_W-1:0] w_b;
        w_a = ua ? Z_W'(a) : {{(Z_W-A_W){a[A_W-1]}}, a};
        w_b = ub ? Z_W'(b) : {{(Z_W-B_W){b[B_W-1]}}, b};
        return w_a * w_b;
    endfunction

endpackage

// File: rtl/rs_dsp_mult_pipe.sv
// LATENCY-stage 20x18 signed/unsigned multiply (DSP38 MULTIPLY mode) carrying
// the requester id alongside the product.
module rs_dsp_mult_pipe
    import rs_dsp_mult_arb_pkg::*;
#(
    parameter int LATENCY = 2
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic [2:0]          i_feedback,
    input  pipe_entry_t         i_op,
    output logic                o_valid,
    output logic [ID_MAX_W-1:0] o_id,
    output logic [Z_W-1:0]      o_z
);

    logic [LATENCY-1:0]               r_vld_pipe;
    logic [LATENCY-1:0][ID_MAX_W-1:0] r_id;
    logic [A_W-1:0]                   r_a;
    logic [B_W-1:0]                   r_b;
    logic                             r_ua;
    logic                             r_ub;
    logic [Z_W-1:0]                   w_prod;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_vld_pipe <= '0;
        end else begin
            r_vld_pipe[0] <= i_op.valid;
            for (int s = 1; s < LATENCY; s++) r_vld_pipe[s] <= r_vld_pipe[s-1];
        end
    end

    // Operand (input) registers; datapath needs no reset, valid bits gate it.
    always_ff @(posedge i_clk) begin
        r_a     <= i_op.a;
        r_b     <= i_op.b;
        r_ua    <= i_op.unsigned_a;
        r_ub    <= i_op.unsigned_b;
        r_id[0] <= i_op.id;
        for (int s = 1; s < LATENCY; s++) r_id[s] <= r_id[s-1];
    end

    assign w_prod = (i_feedback == FEEDBACK_MULT) ? dsp_mult(r_a, r_b, r_ua, r_ub) : '0;

    if (LATENCY == 1) begin : g_zcomb
        assign o_z = w_prod;
    end else begin : g_zreg
        logic [LATENCY-2:0][Z_W-1:0] r_z;
        always_ff @(posedge i_clk) begin
            r_z[0] <= w_prod;
            for (int s = 1; s < LATENCY-1; s++) r_z[s] <= r_z[s-1];
        end
        assign o_z = r_z[LATENCY-2];
    end

    assign o_valid = r_vld_pipe[LATENCY-1];
    assign o_id    = r_id[LATENCY-1];

endmodule

// File: rtl/rs_dsp_mult_arbiter.sv
// Round-robin sharing of one DSP38 multiplier among NUM_REQ requesters, with
// credit-based issue into a 4-entry show-ahead response FIFO.
module rs_dsp_mult_arbiter
    import rs_dsp_mult_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 2
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic [NUM_REQ-1:0]         i_req_valid,
    output logic [NUM_REQ-1:0]         o_req_ready,
    input  logic [NUM_REQ*A_W-1:0]     i_req_a,
    input  logic [NUM_REQ*B_W-1:0]     i_req_b,
    input  logic [NUM_REQ-1:0]         i_req_unsigned_a,
    input  logic [NUM_REQ-1:0]         i_req_unsigned_b,
    output logic                       o_rsp_valid,
    input  logic                       i_rsp_ready,
    output logic [$clog2(NUM_REQ)-1:0] o_rsp_id,
    output logic [Z_W-1:0]             o_rsp_z
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int PTR_W = $clog2(RSP_DEPTH);

    logic [ID_W-1:0]          r_last_grant;
    logic [CNT_W-1:0]         r_outstanding;
    logic [CNT_W-1:0]         r_fifo_cnt;
    logic [PTR_W-1:0]         r_wptr;
    logic [PTR_W-1:0]         r_rptr;
    logic [Z_W-1:0]           r_mem_z  [RSP_DEPTH];
    logic [ID_MAX_W-1:0]      r_mem_id [RSP_DEPTH];

    logic [NUM_REQ-1:0][ID_W-1:0] w_cand;
    logic                     w_gnt_vld;
    logic [ID_W-1:0]          w_gnt_id;
    logic                     w_issue_en;
    logic                     w_issue;
    pipe_entry_t              w_iss;
    logic                     w_pipe_vld;
    logic [ID_MAX_W-1:0]      w_pipe_id;
    logic [Z_W-1:0]           w_pipe_z;
    logic                     w_fifo_empty;
    logic                     w_head_vld;
    logic [ID_MAX_W-1:0]      w_head_id;
    logic [Z_W-1:0]           w_head_z;
    logic                     w_pop;
    logic                     w_fifo_pop;
    logic                     w_push;
    logic                     w_unused_id;

    // Candidate order: last_grant+1, last_grant+2, ... wrapping modulo NUM_REQ.
    always_comb begin
        w_cand = '0;
        for (int i = 0; i < NUM_REQ; i++)
            w_cand[i] = ID_W'((int'(r_last_grant) + i + 1) % NUM_REQ);
    end

    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_id  = '0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (i_req_valid[w_cand[i]]) begin
                w_gnt_vld = 1'b1;
                w_gnt_id  = w_cand[i];
            end
        end
    end

    // A pop this cycle frees a credit, so full credit with a pop still issues.
    assign w_issue_en  = (r_outstanding < CNT_W'(RSP_DEPTH)) || w_pop;
    assign o_req_ready = (!i_reset && w_gnt_vld && w_issue_en) ? (NUM_REQ'(1) << w_gnt_id) : '0;
    assign w_issue     = |(o_req_ready & i_req_valid);

    always_comb begin
        w_iss       = '0;
        w_iss.valid = w_issue;
        w_iss.id    = ID_MAX_W'(w_gnt_id);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_id == ID_W'(i)) begin
                w_iss.a          = i_req_a[i*A_W +: A_W];
                w_iss.b          = i_req_b[i*B_W +: B_W];
                w_iss.unsigned_a = i_req_unsigned_a[i];
                w_iss.unsigned_b = i_req_unsigned_b[i];
            end
        end
    end

    rs_dsp_mult_pipe #(
        .LATENCY    (LATENCY)
    ) u_pipe (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_feedback (FEEDBACK_MULT),
        .i_op       (w_iss),
        .o_valid    (w_pipe_vld),
        .o_id       (w_pipe_id),
        .o_z        (w_pipe_z)
    );

    // Pipeline output bypasses an empty FIFO so the product is visible the
    // cycle it leaves the last stage; it is written only if not taken then.
    assign w_fifo_empty = (r_fifo_cnt == '0);
    assign w_head_vld   = !i_reset && (!w_fifo_empty || w_pipe_vld);
    assign w_head_id    = w_fifo_empty ? w_pipe_id : r_mem_id[r_rptr];
    assign w_head_z     = w_fifo_empty ? w_pipe_z  : r_mem_z[r_rptr];
    assign w_pop        = w_head_vld && i_rsp_ready;
    assign w_fifo_pop   = w_pop && !w_fifo_empty;
    assign w_push       = w_pipe_vld && !(w_fifo_empty && w_pop);

    assign o_rsp_valid  = w_head_vld;
    assign o_rsp_id     = w_head_vld ? w_head_id[ID_W-1:0] : '0;
    assign o_rsp_z      = w_head_vld ? w_head_z : '0;
    assign w_unused_id  = ^w_head_id;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last_grant  <= ID_W'(NUM_REQ - 1);
            r_outstanding <= '0;
            r_fifo_cnt    <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
        end else begin
            if (w_issue) r_last_grant <= w_gnt_id;
            case ({w_issue, w_pop})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
            if (w_push)     r_wptr <= r_wptr + 1'b1;
            if (w_fifo_pop) r_rptr <= r_rptr + 1'b1;
            r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_push) - CNT_W'(w_fifo_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem_z[r_wptr]  <= w_pipe_z;
            r_mem_id[r_wptr] <= w_pipe_id;
        end
    end

endmodule

// File: tb/tb_rs_dsp_mult_arbiter.sv
// Directed and randomized checks of rs_dsp_mult_arbiter against a product
// scoreboard keyed by requester id.
module tb_rs_dsp_mult_arbiter;

    localparam int NR      = 4;
    localparam int LATENCY = 2;
    localparam int N_SOAK  = 10000;

    typedef struct {
        logic [1:0]  id;
        logic [37:0] z;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [NR-1:0]   req_valid, req_ready, ua, ub;
    logic [NR*20-1:0] req_a;
    logic [NR*18-1:0] req_b;
    logic            rsp_valid, rsp_ready;
    logic [1:0]      rsp_id;
    logic [37:0]     rsp_z;

    exp_t            sb[$];
    int              checks, errors, npush, npop;
    logic [NR-1:0]   last_xfer;

    rs_dsp_mult_arbiter #(.NUM_REQ(NR), .LATENCY(LATENCY)) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_a          (req_a),
        .i_req_b          (req_b),
        .i_req_unsigned_a (ua),
        .i_req_unsigned_b (ub),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_id         (rsp_id),
        .o_rsp_z          (rsp_z)
    );

    always #5 clk = ~clk;

    function automatic logic [37:0] model(input logic [19:0] a, input logic [17:0] b,
                                          input logic a_uns, input logic b_uns);
        longint av, bv;
        av = a_uns ? longint'(a) : longint'($signed(a));
        bv = b_uns ? longint'(b) : longint'($signed(b));
        return 38'(av * bv);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Monitor: samples just before each rising edge; transfers push the
    // reference product, pops are compared against the queue head.
    initial begin
        exp_t e;
        last_xfer = '0;
        forever begin
            @(negedge clk);
            #4;
            check("ready_onehot0", 64'($onehot0(req_ready)), 64'd1);
            last_xfer = req_valid & req_ready;
            for (int i = 0; i < NR; i++) begin
                if (last_xfer[i]) begin
                    sb.push_back('{id: 2'(i),
                                   z: model(req_a[i*20 +: 20], req_b[i*18 +: 18], ua[i], ub[i])});
                    npush++;
                end
            end
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("rsp_id", 64'(rsp_id), 64'(e.id));
                    check("rsp_z", 64'(rsp_z), 64'(e.z));
                end
                npop++;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "watchdog");
    end

    task automatic send_one(input int id, input logic [19:0] a, input logic [17:0] b,
                            input logic a_uns, input logic b_uns, input logic [37:0] ez);
        req_a[id*20 +: 20] = a;
        req_b[id*18 +: 18] = b;
        ua[id] = a_uns;
        ub[id] = b_uns;
        req_valid = NR'(1) << id;
        #1 check("single_grant", 64'(req_ready), 64'(NR'(1) << id));
        @(negedge clk);
        req_valid = '0;
        repeat (LATENCY-1) begin
            check("lat_early", 64'(rsp_valid), 64'd0);
            @(negedge clk);
        end
        check("lat_valid", 64'(rsp_valid), 64'd1);
        check("lat_id", 64'(rsp_id), 64'(id));
        check("lat_z", 64'(rsp_z), 64'(ez));
        @(negedge clk);
    endtask

    initial begin
        int acc, guard, base;
        checks = 0; errors = 0; npush = 0; npop = 0;
        reset = 1'b1; req_valid = '0; req_a = '0; req_b = '0; ua = '0; ub = '0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_id", 64'(rsp_id), 64'd0);
        check("rst_rsp_z", 64'(rsp_z), 64'd0);
        req_valid = '1;
        #1 check("rst_req_ready", 64'(req_ready), 64'd0);
        req_valid = '0;
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;

        // Single request and signedness
        send_one(2, 20'h00003, 18'h00005, 1'b1, 1'b1, 38'd15);
        send_one(3, 20'hFFFFF, 18'h00002, 1'b0, 1'b0, 38'h3FFFFFFFFE);
        send_one(3, 20'hFFFFF, 18'h00002, 1'b1, 1'b0, 38'h00001FFFFE);

        // Fairness: all requesters busy, no backpressure
        for (int i = 0; i < NR; i++) begin
            req_a[i*20 +: 20] = 20'($urandom);
            req_b[i*18 +: 18] = 18'($urandom);
            ua[i] = 1'($urandom);
            ub[i] = 1'($urandom);
        end
        req_valid = '1;
        for (int c = 0; c < 12; c++) begin
            #1 check("rr_grant", 64'(req_ready), 64'(NR'(1) << (c % NR)));
            if (c >= LATENCY) begin
                check("rr_rsp_valid", 64'(rsp_valid), 64'd1);
                check("rr_rsp_id", 64'(rsp_id), 64'((c - LATENCY) % NR));
            end
            @(negedge clk);
        end
        req_valid = '0;
        repeat (LATENCY+2) @(negedge clk);
        check("rr_drained", 64'(sb.size()), 64'd0);

        // Backpressure: credits cap acceptance at the FIFO depth
        rsp_ready = 1'b0;
        req_valid = '1;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            #1;
            if (|req_ready) acc++;
            if (rsp_valid && sb.size() != 0) check("bp_hold_z", 64'(rsp_z), 64'(sb[0].z));
            @(negedge clk);
        end
        check("bp_accepts", 64'(acc), 64'd4);
        check("bp_stalled", 64'(req_ready), 64'd0);
        check("bp_rsp_valid", 64'(rsp_valid), 64'd1);
        rsp_ready = 1'b1;
        #1 check("bp_resume", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = '0;
        repeat (LATENCY+6) @(negedge clk);
        check("bp_drained", 64'(sb.size()), 64'd0);

        // Reset with two ops in the pipeline and one in the FIFO
        rsp_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_valid = NR'(1) << k;
            #1 check("mf_grant", 64'(req_ready), 64'(NR'(1) << k));
            @(negedge clk);
        end
        req_valid = '0;
        check("mf_head_valid", 64'(rsp_valid), 64'd1);
        reset = 1'b1;
        npush -= sb.size();
        sb.delete();
        @(negedge clk);
        reset = 1'b0;
        rsp_ready = 1'b1;
        repeat (LATENCY+2) begin
            check("mf_no_stale", 64'(rsp_valid), 64'd0);
            @(negedge clk);
        end
        req_valid = '1;
        #1 check("mf_first_grant", 64'(req_ready), 64'd1);
        @(negedge clk);
        req_valid = '0;
        repeat (LATENCY+2) @(negedge clk);

        // Random soak
        base = npush;
        guard = 0;
        while ((npush - base) < N_SOAK && guard < 60000) begin
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && last_xfer[i]) req_valid[i] = 1'b0;
                if (!req_valid[i] && $urandom_range(1, 0) == 1) begin
                    req_valid[i] = 1'b1;
                    req_a[i*20 +: 20] = 20'($urandom);
                    req_b[i*18 +: 18] = 18'($urandom);
                    ua[i] = 1'($urandom);
                    ub[i] = 1'($urandom);
                end
            end
            rsp_ready = ($urandom_range(3, 0) != 0);
            @(negedge clk);
            guard++;
        end
        check("soak_count", 64'((npush - base) >= N_SOAK), 64'd1);
        req_valid = '0;
        rsp_ready = 1'b1;
        guard = 0;
        while (sb.size() != 0 && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        repeat (LATENCY+2) @(negedge clk);
        check("soak_drained", 64'(sb.size()), 64'd0);
        check("soak_push_pop", 64'(npop), 64'(npush));
        check("soak_idle", 64'(rsp_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
